rv32_data_mem_responder: RTL and testbench
==========================================

Name: rv32_data_mem_responder

Overview:
Data-memory responder (target side) for the RV32 core's data port: data_mem_enable, data_addr_bus, write_data, data_mem_read, read_data. It owns a word-organised RAM, a small memory-mapped I/O window (LED register, cycle counter), fault detection and access statistics. It sits beside the CPU top in the testbench or FPGA wrapper. There is no ready/stall signal, so every access completes with fixed timing.

Parameters:
DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, min 16; index width IDX_W = clog2(DEPTH_WORDS).
MMIO_BASE, 32'h0001_0000, byte address of MMIO window, word aligned; must lie above the RAM byte range.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  synchronous, active-low reset.
data_mem_enable  in  1  access request this cycle.
data_addr_bus  in  32  byte address.
write_data  in  32  store data.
data_mem_read  in  1  1 = load, 0 = store; sampled only when data_mem_enable=1.
read_data  out  32  registered load data.
led_out  out  16  MMIO LED register.
access_fault  out  1  one-cycle pulse for a rejected access.
rd_count  out  16  accepted loads, saturating.
wr_count  out  16  accepted stores, saturating.

Behaviour:
- Reset: on posedge with rst_n=0, the following clear to 0: read_data, led_out, access_fault, rd_count, wr_count, cycle_ctr. RAM contents are not reset. A request present in a reset cycle is ignored entirely.
- Decode, when data_mem_enable=1:
  - misaligned: addr[1:0]!=0.
  - RAM hit: aligned and addr < DEPTH_WORDS*4. Index is addr[IDX_W+1:2].
  - LED hit: addr==MMIO_BASE.
  - CYC hit: addr==MMIO_BASE+4.
  - Anything else is out-of-range.
- Load (enable=1, read=1): read_data updates at the same posedge.
  - RAM hit: mem[idx].
  - LED hit: {16'h0, led_out}.
  - CYC hit: cycle_ctr.
  - Data is visible to the core one cycle after the request (1-cycle latency).
  - read_data holds its value until the next accepted or faulting load.
- Store (enable=1, read=0):
  - RAM hit: mem[idx] <= write_data.
  - LED hit: led_out <= write_data[15:0].
  - CYC hit: store is rejected (read-only).
- Fault conditions: misaligned, out-of-range, or a store to CYC.
  - Fault response: access_fault=1 for exactly one cycle after the request. Stores are dropped. Loads set read_data=32'hDEAD_BEEF. Counters do not increment.
  - Consecutive faulting requests keep access_fault high continuously.
- Ordering: a store at cycle N followed by a load of the same address at cycle N+1 returns the new data. No read-during-write case exists (single request per cycle).
- enable=0: no state changes except cycle_ctr. data_mem_read and write_data are don't-care.
- cycle_ctr: 32-bit free-running counter, increments every non-reset cycle, wraps 32'hFFFF_FFFF -> 0.
- rd_count/wr_count: +1 per accepted load/store; stick at 16'hFFFF.

Optional Feature:
Macro RV32_MEM_MMIO_EN.
- Defined: the MMIO window decodes as described above.
- Undefined: LED and CYC hits are treated as out-of-range (fault, DEAD_BEEF on loads). led_out is tied to 0, and the cycle_ctr logic is removed.

Test Plan:
- Store 32'h1234_5678 to 0x10, load 0x10 next cycle -> read_data=32'h1234_5678 one cycle after the load; wr_count=1, rd_count=1, access_fault stays 0.
- Load 0x12 (misaligned) -> access_fault=1 for one cycle, read_data=32'hDEAD_BEEF, rd_count unchanged. Store to 0x1000 with DEPTH_WORDS=1024 -> fault, RAM unchanged.
- Store 32'hABCD_00FF to MMIO_BASE -> led_out=16'h00FF next cycle. Load MMIO_BASE -> 32'h0000_00FF. Store to MMIO_BASE+4 -> fault.
- 70000 back-to-back stores to 0x0 -> wr_count saturates at 16'hFFFF; mem[0] holds the final data.
- Assert rst_n=0 for one cycle during a store burst -> that store is dropped; all outputs read 0 after reset; the earlier RAM contents remain readable.
- Macro undefined: load MMIO_BASE -> fault plus DEAD_BEEF; led_out remains 0 after a store there.

Source files
------------

// File: rtl/rv32_data_mem_responder.sv
// rv32_data_mem_responder
// Target-side responder for the RV32 core's data port. Owns a word-organised
// RAM, a small MMIO window (LED register and free-running cycle counter),
// access-fault detection and saturating load/store statistics. There is no
// stall path: every request is resolved at the posedge it is presented on,
// and load data appears on read_data one cycle after the request.
//
// Build option: define RV32_MEM_MMIO_EN to enable the MMIO window. Without it
// the LED and cycle-counter addresses decode as out-of-range, led_out is tied
// to zero and the cycle counter is not built.

module rv32_data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_mem_enable,
   input  logic [31:0] data_addr_bus,
   input  logic [31:0] write_data,
   input  logic        data_mem_read,
   output logic [31:0] read_data,
   output logic [15:0] led_out,
   output logic        access_fault,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES  = 32'(DEPTH_WORDS * 4);
   localparam logic [31:0] CYC_ADDR   = MMIO_BASE + 32'd4;
   localparam logic [31:0] FAULT_DATA = 32'hDEAD_BEEF;
   localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

`ifdef RV32_MEM_MMIO_EN
   localparam bit MMIO_ON = 1'b1;
`else
   localparam bit MMIO_ON = 1'b0;
`endif

   logic [31:0]      r_mem [DEPTH_WORDS];
   logic [31:0]      r_readData;
   logic             r_fault;
   logic [15:0]      r_rdCount;
   logic [15:0]      r_wrCount;

   logic [IDX_W-1:0] w_idx;
   logic             w_aligned;
   logic             w_ramHit;
   logic             w_ledHit;
   logic             w_cycHit;
   logic             w_anyHit;
   logic             w_fault;
   logic             w_acceptLoad;
   logic             w_acceptStore;
   logic             w_ramWrite;
   logic             w_ledWrite;
   logic [15:0]      w_ledValue;
   logic [31:0]      w_cycValue;

   assign w_idx = data_addr_bus[IDX_W+1:2];

   // Address decode and fault classification for the request on the bus.
   // LED/CYC addresses are word aligned by construction, so alignment only
   // needs to gate the RAM range check. Stores to the cycle counter are
   // rejected because it is read-only.
   always_comb begin
      w_aligned     = (data_addr_bus[1:0] == 2'b00);
      w_ramHit      = w_aligned && (data_addr_bus < RAM_BYTES);
      w_ledHit      = MMIO_ON && (data_addr_bus == MMIO_BASE);
      w_cycHit      = MMIO_ON && (data_addr_bus == CYC_ADDR);
      w_anyHit      = w_ramHit || w_ledHit || w_cycHit;
      w_fault       = data_mem_enable &&
                      (!w_anyHit || (w_cycHit && !data_mem_read));
      w_acceptLoad  = data_mem_enable && data_mem_read && !w_fault;
      w_acceptStore = data_mem_enable && !data_mem_read && !w_fault;
      w_ramWrite    = w_acceptStore && w_ramHit;
      w_ledWrite    = w_acceptStore && w_ledHit;
   end

   // RAM write port; contents deliberately survive reset, but a request
   // presented during a reset cycle must not land.
   always_ff @(posedge clk) begin
      if (rst_n && w_ramWrite) begin
         r_mem[w_idx] <= write_data;
      end
   end

   // Registered load data: updates only on loads (accepted or faulting) and
   // otherwise holds the last returned value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_readData <= '0;
      end else if (data_mem_enable && data_mem_read) begin
         if (w_fault) begin
            r_readData <= FAULT_DATA;
         end else if (w_ramHit) begin
            r_readData <= r_mem[w_idx];
         end else if (w_ledHit) begin
            r_readData <= {16'h0000, w_ledValue};
         end else if (w_cycHit) begin
            r_readData <= w_cycValue;
         end
      end
   end

   // Fault flag mirrors the previous cycle's decode, so back-to-back faulting
   // requests hold it high without a gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_fault;
      end
   end

   // Accepted-load counter, sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdCount <= '0;
      end else if (w_acceptLoad && (r_rdCount != COUNT_MAX)) begin
         r_rdCount <= r_rdCount + 16'd1;
      end
   end

   // Accepted-store counter, sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrCount <= '0;
      end else if (w_acceptStore && (r_wrCount != COUNT_MAX)) begin
         r_wrCount <= r_wrCount + 16'd1;
      end
   end

`ifdef RV32_MEM_MMIO_EN
   logic [15:0] r_led;
   logic [31:0] r_cycleCtr;

   // LED register takes the low half of a store to the LED address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_led <= '0;
      end else if (w_ledWrite) begin
         r_led <= write_data[15:0];
      end
   end

   // Free-running cycle counter; wraps naturally at 32 bits. A load of it
   // returns the value held before this edge's increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cycleCtr <= '0;
      end else begin
         r_cycleCtr <= r_cycleCtr + 32'd1;
      end
   end

   assign w_ledValue = r_led;
   assign w_cycValue = r_cycleCtr;
`else
   assign w_ledValue = 16'h0000;
   assign w_cycValue = 32'h0000_0000;
`endif

   assign read_data    = r_readData;
   assign led_out      = w_ledValue;
   assign access_fault = r_fault;
   assign rd_count     = r_rdCount;
   assign wr_count     = r_wrCount;

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Testbench for rv32_data_mem_responder: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the memory map.

module tb_rv32_data_mem_responder;

   localparam int unsigned DEPTH     = 1024;
   localparam logic [31:0] BASE      = 32'h0001_0000;
`ifdef RV32_MEM_MMIO_EN
   localparam bit          MMIO_ON   = 1'b1;
`else
   localparam bit          MMIO_ON   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_mem_enable;
   logic [31:0] data_addr_bus;
   logic [31:0] write_data;
   logic        data_mem_read;
   logic [31:0] read_data;
   logic [15:0] led_out;
   logic        access_fault;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [31:0] mdlMem [int];
   logic [31:0] expRead;
   logic [15:0] expLed;
   logic        expFault;
   logic [15:0] expRd;
   logic [15:0] expWr;
   logic [31:0] expCyc;

   rv32_data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .data_mem_enable (data_mem_enable),
      .data_addr_bus   (data_addr_bus),
      .write_data      (write_data),
      .data_mem_read   (data_mem_read),
      .read_data       (read_data),
      .led_out         (led_out),
      .access_fault    (access_fault),
      .rd_count        (rd_count),
      .wr_count        (wr_count)
   );

   always #5 clk = ~clk;

   // Drive one request, let one posedge pass, then advance the model.
   task automatic step(input logic en, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rstn);
      logic [31:0] cycBefore;
      int kind;
      rst_n = rstn;
      data_mem_enable = en;
      data_mem_read = rd;
      data_addr_bus = addr;
      write_data = wd;
      @(posedge clk);
      #1;
      if (!rstn) begin
         expRead = 0; expLed = 0; expFault = 0; expRd = 0; expWr = 0; expCyc = 0;
         return;
      end
      cycBefore = expCyc;
      expCyc = expCyc + 1;
      expFault = 0;
      if (!en) return;
      // kind: 0 RAM, 1 LED, 2 CYC, 3 rejected
      if ((addr % 4) != 0) kind = 3;
      else if (addr < DEPTH * 4) kind = 0;
      else if (MMIO_ON && addr == BASE) kind = 1;
      else if (MMIO_ON && addr == BASE + 4) kind = 2;
      else kind = 3;
      if (kind == 2 && !rd) kind = 3;
      if (kind == 3) begin
         expFault = 1;
         if (rd) expRead = 32'hDEAD_BEEF;
      end else if (rd) begin
         if (kind == 0) expRead = mdlMem[int'(addr / 4)];
         else if (kind == 1) expRead = {16'h0, expLed};
         else expRead = cycBefore;
         if (expRd != 16'hFFFF) expRd = expRd + 1;
      end else begin
         if (kind == 0) mdlMem[int'(addr / 4)] = wd;
         else expLed = wd[15:0];
         if (expWr != 16'hFFFF) expWr = expWr + 1;
      end
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, 0);
      step(1, 0, 32'h10, 32'h5555_AAAA, 0);
      checks++; if (read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_read got=%h exp=0", read_data); end
      checks++; if (led_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_led got=%h exp=0", led_out); end
      checks++; if (access_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got=%b exp=0", access_fault); end
      checks++; if (rd_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_rd got=%h exp=0", rd_count); end
      checks++; if (wr_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_wr got=%h exp=0", wr_count); end
   endtask

   task automatic test_store_load();
      step(1, 0, 32'h10, 32'h1234_5678, 1);
      checks++; if (access_fault !== 1'b0) begin errors++; $display("[TB] FAIL sl_store_fault got=%b exp=0", access_fault); end
      checks++; if (wr_count !== 16'd1) begin errors++; $display("[TB] FAIL sl_wr got=%0d exp=1", wr_count); end
      step(1, 1, 32'h10, 32'h0, 1);
      checks++; if (read_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL sl_read got=%h exp=12345678", read_data); end
      checks++; if (rd_count !== 16'd1) begin errors++; $display("[TB] FAIL sl_rd got=%0d exp=1", rd_count); end
      checks++; if (access_fault !== 1'b0) begin errors++; $display("[TB] FAIL sl_load_fault got=%b exp=0", access_fault); end
      // Idle cycle: read_data must hold
      step(0, 1, 32'h10, 32'h0, 1);
      checks++; if (read_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL sl_hold got=%h exp=12345678", read_data); end
   endtask

   task automatic test_faults();
      step(1, 0, 32'h0, 32'hCAFE_0001, 1);
      step(1, 1, 32'h12, 32'h0, 1);
      checks++; if (access_fault !== 1'b1) begin errors++; $display("[TB] FAIL misal_fault got=%b exp=1", access_fault); end
      checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL misal_read got=%h exp=deadbeef", read_data); end
      checks++; if (rd_count !== expRd) begin errors++; $display("[TB] FAIL misal_rd got=%0d exp=%0d", rd_count, expRd); end
      // Out-of-range store aliasing index 0 must not land; consecutive faults
      step(1, 0, 32'h1000, 32'hBAD0_BAD0, 1);
      checks++; if (access_fault !== 1'b1) begin errors++; $display("[TB] FAIL oor_fault got=%b exp=1", access_fault); end
      checks++; if (wr_count !== expWr) begin errors++; $display("[TB] FAIL oor_wr got=%0d exp=%0d", wr_count, expWr); end
      step(1, 1, 32'h0, 32'h0, 1);
      checks++; if (access_fault !== 1'b0) begin errors++; $display("[TB] FAIL oor_clear got=%b exp=0", access_fault); end
      checks++; if (read_data !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL oor_ram got=%h exp=cafe0001", read_data); end
      step(0, 0, 32'h0, 32'h0, 1);
      checks++; if (access_fault !== 1'b0) begin errors++; $display("[TB] FAIL idle_fault got=%b exp=0", access_fault); end
   endtask

   task automatic test_mmio();
      step(1, 0, BASE, 32'hABCD_00FF, 1);
`ifdef RV32_MEM_MMIO_EN
      checks++; if (led_out !== 16'h00FF) begin errors++; $display("[TB] FAIL led_store got=%h exp=00ff", led_out); end
      checks++; if (access_fault !== 1'b0) begin errors++; $display("[TB] FAIL led_fault got=%b exp=0", access_fault); end
      step(1, 1, BASE, 32'h0, 1);
      checks++; if (read_data !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL led_load got=%h exp=000000ff", read_data); end
      step(1, 0, BASE + 4, 32'h1, 1);
      checks++; if (access_fault !== 1'b1) begin errors++; $display("[TB] FAIL cyc_store got=%b exp=1", access_fault); end
      step(1, 1, BASE + 4, 32'h0, 1);
      checks++; if (read_data !== expRead) begin errors++; $display("[TB] FAIL cyc_load got=%h exp=%h", read_data, expRead); end
`else
      checks++; if (access_fault !== 1'b1) begin errors++; $display("[TB] FAIL led_store_fault got=%b exp=1", access_fault); end
      checks++; if (led_out !== 16'h0) begin errors++; $display("[TB] FAIL led_tied got=%h exp=0", led_out); end
      step(1, 1, BASE, 32'h0, 1);
      checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL led_load got=%h exp=deadbeef", read_data); end
      checks++; if (access_fault !== 1'b1) begin errors++; $display("[TB] FAIL led_load_fault got=%b exp=1", access_fault); end
      step(1, 1, BASE + 4, 32'h0, 1);
      checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL cyc_load got=%h exp=deadbeef", read_data); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int sel;
      for (int i = 0; i < 32; i++) step(1, 0, 32'(i * 4), $urandom, 1);
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3, 4: addr = 32'($urandom_range(0, 31) * 4);
            5: addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            6: addr = 32'h1000 + 32'($urandom_range(0, 1000) * 4);
            7: addr = BASE;
            8: addr = BASE + 4;
            default: addr = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
         endcase
         step($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, addr, $urandom, 1);
         checks++; if (read_data !== expRead) begin errors++; $display("[TB] FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, addr, read_data, expRead); end
         checks++; if (access_fault !== expFault) begin errors++; $display("[TB] FAIL rand_fault n=%0d addr=%h got=%b exp=%b", n, addr, access_fault, expFault); end
         checks++; if (led_out !== expLed) begin errors++; $display("[TB] FAIL rand_led n=%0d got=%h exp=%h", n, led_out, expLed); end
         checks++; if (rd_count !== expRd) begin errors++; $display("[TB] FAIL rand_rd n=%0d got=%0d exp=%0d", n, rd_count, expRd); end
         checks++; if (wr_count !== expWr) begin errors++; $display("[TB] FAIL rand_wr n=%0d got=%0d exp=%0d", n, wr_count, expWr); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 70000; i++) step(1, 0, 32'h0, 32'(i) ^ 32'h5A00_0000, 1);
      checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_wr got=%h exp=ffff", wr_count); end
      checks++; if (wr_count !== expWr) begin errors++; $display("[TB] FAIL sat_wr_model got=%h exp=%h", wr_count, expWr); end
      step(1, 1, 32'h0, 32'h0, 1);
      checks++; if (read_data !== (32'd69999 ^ 32'h5A00_0000)) begin errors++; $display("[TB] FAIL sat_data got=%h exp=%h", read_data, 32'd69999 ^ 32'h5A00_0000); end
   endtask

   task automatic test_reset_midburst();
      step(1, 0, 32'd45 * 4, 32'hAAAA_5555, 1);
      step(1, 0, BASE, 32'h0000_1234, 1);
      for (int i = 40; i < 50; i++) step(1, 0, 32'(i * 4), 32'h7700_0000 + 32'(i), (i != 45));
      checks++; if (read_data !== 32'h0 || rd_count !== 16'h0) begin errors++; $display("[TB] FAIL mid_rd got=%h/%0d exp=0/0", read_data, rd_count); end
      checks++; if (wr_count !== 16'd4) begin errors++; $display("[TB] FAIL mid_wr got=%0d exp=4", wr_count); end
      checks++; if (led_out !== 16'h0) begin errors++; $display("[TB] FAIL mid_led got=%h exp=0", led_out); end
      step(1, 1, 32'd45 * 4, 32'h0, 1);
      checks++; if (read_data !== 32'hAAAA_5555) begin errors++; $display("[TB] FAIL mid_drop got=%h exp=aaaa5555", read_data); end
      step(1, 1, 32'd44 * 4, 32'h0, 1);
      checks++; if (read_data !== 32'h7700_002C) begin errors++; $display("[TB] FAIL mid_keep got=%h exp=7700002c", read_data); end
      checks++; if (read_data !== expRead) begin errors++; $display("[TB] FAIL mid_model got=%h exp=%h", read_data, expRead); end
   endtask

   initial begin
      rst_n = 1'b0;
      data_mem_enable = 1'b0;
      data_mem_read = 1'b0;
      data_addr_bus = '0;
      write_data = '0;
      test_reset();
      test_store_load();
      test_faults();
      test_mmio();
      test_random();
      test_back_to_back();
      test_reset_midburst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
